// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction-fetch stage. Owns the PC, looks it up in the
// Icache combinationally, refills the Icache from the memory controller on a
// miss and issues hits to the instruction queue one per cycle.
// Optional static branch predecode is enabled by defining IF_BPRED_EN.
module inst_fetcher #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic [XLEN-1:0] if_to_ic_fetch_addr,
  input  logic            ic_to_if_hit,
  input  logic [XLEN-1:0] ic_to_if_hit_inst,
  output logic [XLEN-1:0] if_to_ic_update_addr,
  output logic [XLEN-1:0] if_to_ic_inst,
  output logic            if_to_ic_inst_valid,
  output logic            if_to_mc_en,
  output logic [XLEN-1:0] if_to_mc_addr,
  input  logic            mc_to_if_done,
  input  logic [XLEN-1:0] mc_to_if_inst,
  input  logic            iq_to_if_full,
  input  logic            rob_to_if_jump,
  input  logic [XLEN-1:0] rob_to_if_jump_addr,
  output logic            if_to_iq_valid,
  output logic [XLEN-1:0] if_to_iq_inst,
  output logic [XLEN-1:0] if_to_iq_pc,
  output logic            if_to_iq_pred_jump
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] next_pc;
  logic            pred_jump;
  logic            issue, req, refill;

  assign if_to_ic_fetch_addr = pc;
  assign if_to_mc_addr       = mem_addr;

`ifdef IF_BPRED_EN
  logic [6:0]      opcode;
  logic [XLEN-1:0] j_imm, b_imm;

  assign opcode = ic_to_if_hit_inst[6:0];
  assign j_imm  = {{(XLEN-21){ic_to_if_hit_inst[31]}}, ic_to_if_hit_inst[31],
                   ic_to_if_hit_inst[19:12], ic_to_if_hit_inst[20],
                   ic_to_if_hit_inst[30:21], 1'b0};
  assign b_imm  = {{(XLEN-13){ic_to_if_hit_inst[31]}}, ic_to_if_hit_inst[31],
                   ic_to_if_hit_inst[7], ic_to_if_hit_inst[30:25],
                   ic_to_if_hit_inst[11:8], 1'b0};

  // Static predecode: JAL always taken, backward conditional branches taken.
  always_comb begin
    pred_jump = 1'b0;
    next_pc   = pc + XLEN'(4);
    if (opcode == 7'b1101111) begin
      pred_jump = 1'b1;
      next_pc   = pc + j_imm;
    end else if (opcode == 7'b1100011 && ic_to_if_hit_inst[31]) begin
      pred_jump = 1'b1;
      next_pc   = pc + b_imm;
    end
  end
`else
  assign pred_jump = 1'b0;
  assign next_pc   = pc + XLEN'(4);
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // Next state and per-cycle actions. While a refill strobe is out the
  // Icache has not yet absorbed the word, so a miss that cycle is held off
  // rather than re-requested; the following cycle then hits.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    req       = 1'b0;
    refill    = 1'b0;
    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (!rob_to_if_jump) begin
            if (ic_to_if_hit) begin
              issue = !iq_to_if_full;
            end else if (!if_to_ic_inst_valid) begin
              req       = 1'b1;
              state_nxt = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (mc_to_if_done) begin
            refill    = 1'b1;
            state_nxt = IDLE;
          end else if (rob_to_if_jump) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (mc_to_if_done) begin
            refill    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // PC, memory request, refill and issue registers; all frozen when !rdy_in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc                   <= RESET_PC;
      mem_addr             <= '0;
      if_to_mc_en          <= 1'b0;
      if_to_ic_update_addr <= '0;
      if_to_ic_inst        <= '0;
      if_to_ic_inst_valid  <= 1'b0;
      if_to_iq_valid       <= 1'b0;
      if_to_iq_inst        <= '0;
      if_to_iq_pc          <= '0;
      if_to_iq_pred_jump   <= 1'b0;
    end else if (rdy_in) begin
      if_to_iq_valid      <= issue;
      if_to_ic_inst_valid <= refill;
      if (issue) begin
        if_to_iq_inst      <= ic_to_if_hit_inst;
        if_to_iq_pc        <= pc;
        if_to_iq_pred_jump <= pred_jump;
      end
      if (rob_to_if_jump) pc <= rob_to_if_jump_addr;
      else if (issue)     pc <= next_pc;
      // The MC transaction always completes, even after a redirect.
      if (req) begin
        mem_addr    <= pc;
        if_to_mc_en <= 1'b1;
      end else if (refill) begin
        if_to_mc_en <= 1'b0;
      end
      if (refill) begin
        if_to_ic_update_addr <= mem_addr;
        if_to_ic_inst        <= mc_to_if_inst;
      end
    end
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction-fetch stage of the RISC-V core.
- Owns the PC and looks up each PC in the Icache combinationally.
- On a miss, requests the word from the memory controller and refills the Icache; hits are delivered one per cycle to the decoder/instruction queue.
- Handles redirects from the ROB, including a redirect that arrives while a memory fetch is outstanding.

Parameters:
- RESET_PC, 32'h0, PC value loaded at reset.
- XLEN, 32, address and instruction width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; low freezes all state and outputs
- if_to_ic_fetch_addr  out  XLEN  lookup address, always equals pc
- ic_to_if_hit  in  1  Icache hit for fetch addr (combinational)
- ic_to_if_hit_inst  in  XLEN  hit instruction
- if_to_ic_update_addr  out  XLEN  refill address
- if_to_ic_inst  out  XLEN  refill data
- if_to_ic_inst_valid  out  1  refill write strobe, 1-cycle pulse
- if_to_mc_en  out  1  memory fetch request, held until done
- if_to_mc_addr  out  XLEN  memory fetch address
- mc_to_if_done  in  1  1-cycle pulse, data valid
- mc_to_if_inst  in  XLEN  fetched word
- iq_to_if_full  in  1  downstream cannot accept this cycle
- rob_to_if_jump  in  1  redirect (mispredict/flush)
- rob_to_if_jump_addr  in  XLEN  redirect target
- if_to_iq_valid  out  1  registered 1-cycle issue pulse
- if_to_iq_inst  out  XLEN  issued instruction
- if_to_iq_pc  out  XLEN  PC of issued instruction
- if_to_iq_pred_jump  out  1  predicted-taken flag

Behaviour:
- Reset (rst_in=0, async):
  - pc=RESET_PC, state=IDLE.
  - All outputs 0, except if_to_ic_fetch_addr=RESET_PC.
- rdy_in=0: no state or register change; strobes hold their previous values.
- States: IDLE, WAIT_MEM, DRAIN.
- Priority every cycle: reset > !rdy_in > rob_to_if_jump > normal operation.
- IDLE:
  - hit && !full: issue {inst, pc}, valid=1 next cycle, pc<=next_pc.
  - hit && full: valid=0, pc holds.
  - miss: mem_addr<=pc, if_to_mc_en<=1, go to WAIT_MEM.
- WAIT_MEM:
  - if_to_mc_en=1, if_to_mc_addr=mem_addr held stable.
  - On mc_to_if_done: if_to_mc_en<=0; refill pulse (update_addr=mem_addr, inst=mc_to_if_inst, inst_valid=1 for exactly 1 cycle); go to IDLE.
  - The next IDLE cycle hits; no direct bypass to the IQ.
  - Miss-to-issue latency = mem latency + 2 cycles.
- Redirect (rob_to_if_jump=1):
  - pc<=rob_to_if_jump_addr; if_to_iq_valid<=0 next cycle.
  - From IDLE: stay IDLE.
  - From WAIT_MEM: go to DRAIN. The MC transaction is not aborted; en stays high with the old mem_addr.
  - In DRAIN: redirect only updates pc.
- DRAIN:
  - On done: refill the Icache with the old address/data (still correct), then go to IDLE.
  - The instruction is not issued.
- Simultaneous done and jump in WAIT_MEM: refill happens, state goes to IDLE, pc<=jump target.
- next_pc = pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- if_to_iq_valid, if_to_ic_inst_valid: never high two consecutive cycles for the same instruction/refill.
- Width: all addresses XLEN; no alignment check (pc[1:0] carried through).

Optional Feature:
- Macro: IF_BPRED_EN.
- Defined: static predecode of the hit instruction.
  - JAL (opcode 1101111): next_pc=pc+sext(J-imm), pred_jump=1.
  - B-type (1100011) with negative imm: next_pc=pc+sext(B-imm), pred_jump=1.
  - Otherwise pc+4, pred_jump=0.
  - JALR is always pc+4.
- Undefined: next_pc=pc+4 always, if_to_iq_pred_jump tied 0; no predecode logic.

Test Plan:
- Reset with RESET_PC=0: fetch_addr=0, all strobes 0, mc_en=0.
- pc=0 miss, MC done after 3 cycles with 32'h00500093:
  - mc_addr=0 until done, then 1-cycle refill pulse at addr 0.
  - Next cycle hit; valid with pc=0, inst=32'h00500093; pc becomes 4.
- Back-to-back hits at 0,4,8 with full=0: valid on 3 consecutive cycles.
- full=1 for 2 cycles during hits: no valid, pc holds; resumes on full=0.
- Jump to 0x100 in WAIT_MEM for addr 0x8:
  - en stays high with mc_addr=0x8; done refills 0x8; no issue of that word.
  - Next fetch_addr=0x100.
- IF_BPRED_EN, hit JAL x0,-8 at pc=0x20: issue pred_jump=1; next pc=0x18.
- Without the macro, same stimulus: next pc=0x24, pred_jump=0.
